spp_repacketizer: RTL
=====================

SPP_REPACKETIZER -- requirements
Module: spp_repacketizer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter MAX_LEN_LOG2, default 10, width of max_spp and of the internal sample counter.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush, active-high.
REQ-006 SHALL have port max_spp  input  MAX_LEN_LOG2  maximum samples per output packet; 0 means no limit.
REQ-007 SHALL have ports i_tdata (input, WIDTH), i_tlast (input, 1), i_tvalid (input, 1) and i_tready (output, 1): AXI-Stream sink fed by the variable-delay stage.
REQ-008 SHALL have ports o_tdata (output, WIDTH), o_tlast (output, 1), o_tvalid (output, 1) and o_tready (input, 1): AXI-Stream source.

Function
REQ-009 SHALL restore packet framing downstream of the delay stage, which drops tlast on inserted samples and can produce unbounded packets.
REQ-010 SHALL register its output through a 2-entry skid buffer: 1-cycle latency, full throughput, no combinational path from o_tready to i_tready.
REQ-011 SHALL use buffer states EMPTY, ONE and FULL, with i_tready = (state != FULL), driven from a register.
REQ-012 SHALL transition EMPTY->ONE on an input beat; ONE->FULL on an input beat without an output beat; ONE->EMPTY on an output beat without an input beat; FULL->ONE on an output beat; simultaneous input and output beats SHALL hold the state.
REQ-013 SHALL keep a sample counter spp_count that increments on each accepted input beat and returns to 0 after any beat tagged last.
REQ-014 SHALL tag a beat last when i_tlast=1, or when max_spp!=0 and spp_count==max_spp-1 (forced split).
REQ-015 SHALL sample max_spp only when spp_count==0 (packet start) and hold the latched value for the whole packet.
REQ-016 SHALL pass a beat unchanged with o_tlast=1 when i_tlast and a forced split coincide; this SHALL produce exactly one tlast.
REQ-017 SHALL not alter data: o_tdata order and values SHALL equal i_tdata order and values.
REQ-018 SHALL hold o_tdata and o_tlast stable while o_tvalid=1 and o_tready=0.
REQ-019 SHALL treat max_spp=1 as a tlast on every beat.

Reset
REQ-020 SHALL, on reset_n=0 (asynchronous), force state=EMPTY, o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=0, spp_count=0 and latched max_spp=0.
REQ-021 SHALL raise i_tready on the first clk edge after reset_n deasserts.
REQ-022 SHALL, on clear=1, discard buffered beats and return to the reset state, except that i_tready=1 on the next cycle; clear SHALL win over any simultaneous beat.
REQ-023 SHALL treat reset or clear asserted mid-packet as a new packet start, with no tlast emitted for the truncated packet.

Configuration
REQ-024 SHALL, when macro SPP_REPACK_STATS_EN is defined, add outputs o_pkt_count[31:0] (output beats with o_tlast=1) and o_split_count[31:0] (forced splits with i_tlast=0).
REQ-025 SHALL clear both counters on reset or clear and let them wrap at 2^32.
REQ-026 SHALL, when SPP_REPACK_STATS_EN is undefined, omit both ports and their logic, with all other behaviour identical.

Structure
REQ-027 SHALL place the buffer-state encoding (EMPTY=0, ONE=1, FULL=2) and the counter width constant (32) in shared package spp_repack_pkg.
REQ-028 SHALL implement the 2-entry buffer as sub-module spp_skid_reg, parameterized by WIDTH+1 (data plus last); framing logic SHALL stay in the top module.

Verification
REQ-029 SHALL cover: max_spp=4, 10 beats continuous, i_tlast=0 throughout -> o_tlast on beats 4 and 8; beat 10 untagged; o_split_count=2.
REQ-030 SHALL cover: max_spp=0, i_tlast on beat 6 -> single packet of 6, pass-through framing.
REQ-031 SHALL cover: max_spp=3, i_tlast on beat 3 -> exactly one tlast on beat 3; o_pkt_count=1 and o_split_count=0.
REQ-032 SHALL cover: random o_tready at 50%, 1000 beats -> no data loss or duplication, and data held stable during stalls.
REQ-033 SHALL cover: max_spp changed from 4 to 2 after beat 2 -> first packet still 4 beats, then packets of 2.
REQ-034 SHALL cover: reset_n pulsed low mid-packet at beat 2 of 4 -> outputs 0 immediately and the next packet counts from 0.

Source files
------------

// File: rtl/spp_repack_pkg.sv
// Shared constants for the SPP repacketizer: skid-buffer state encoding and statistics counter width.
package spp_repack_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam int STAT_CNT_W = 32;

endpackage

// File: rtl/spp_skid_reg.sv
// Two-entry registered skid buffer: one-cycle latency, full throughput, in_ready_o driven from a flop.
//
// state     | meaning
// BUF_EMPTY | no beat held, output idle
// BUF_ONE   | one beat in the output register
// BUF_FULL  | output register plus skid register occupied, input stalled
module spp_skid_reg
  import spp_repack_pkg::*;
#(
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  buf_state_e    state_q, state_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          ready_q, ready_d;
  logic          in_beat, out_beat;

  assign in_ready_o  = ready_q;
  assign out_data_o  = out_q;
  assign out_valid_o = (state_q != BUF_EMPTY);

  assign in_beat  = in_valid_i & ready_q;
  assign out_beat = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BUF_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (clear) begin
      state_d = BUF_EMPTY;
      out_d   = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (in_beat) begin
            out_d   = in_data_i;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_beat && out_beat) begin
            out_d = in_data_i;
          end else if (in_beat) begin
            skid_d  = in_data_i;
            state_d = BUF_FULL;
          end else if (out_beat) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          // ready_q is low here, so no input beat can arrive alongside the drain
          if (out_beat) begin
            out_d   = skid_q;
            state_d = BUF_ONE;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
    ready_d = (state_d != BUF_FULL);
  end

endmodule

// File: rtl/spp_repacketizer.sv
// Restores packet framing after the variable-delay stage, splitting packets at max_spp samples.
// Optional statistics outputs (packet and forced-split counts) are enabled by SPP_REPACK_STATS_EN.
module spp_repacketizer
  import spp_repack_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int MAX_LEN_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [MAX_LEN_LOG2-1:0] max_spp,
  input  logic [WIDTH-1:0]        i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [WIDTH-1:0]        o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready
`ifdef SPP_REPACK_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0]   o_pkt_count,
  output logic [STAT_CNT_W-1:0]   o_split_count
`endif
);

  localparam logic [MAX_LEN_LOG2-1:0] CNT_ONE = MAX_LEN_LOG2'(1);

  logic [MAX_LEN_LOG2-1:0] spp_count_q, spp_count_d;
  logic [MAX_LEN_LOG2-1:0] max_q, max_d;
  logic [MAX_LEN_LOG2-1:0] eff_max;
  logic                    in_beat, force_split, tag_last;
  logic [WIDTH:0]          buf_out;

  assign in_beat = i_tvalid & i_tready;

  // At packet start the live max_spp applies; afterwards the latched copy holds
  always_comb begin
    eff_max     = (spp_count_q == '0) ? max_spp : max_q;
    force_split = (eff_max != '0) && (spp_count_q == eff_max - CNT_ONE);
    tag_last    = i_tlast | force_split;
    spp_count_d = spp_count_q;
    max_d       = max_q;
    if (clear) begin
      spp_count_d = '0;
      max_d       = '0;
    end else if (in_beat) begin
      if (spp_count_q == '0) max_d = max_spp;
      spp_count_d = tag_last ? '0 : spp_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spp_count_q <= '0;
      max_q       <= '0;
    end else begin
      spp_count_q <= spp_count_d;
      max_q       <= max_d;
    end
  end

  spp_skid_reg #(
    .DW(WIDTH + 1)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .in_data_i  ({tag_last, i_tdata}),
    .in_valid_i (i_tvalid),
    .in_ready_o (i_tready),
    .out_data_o (buf_out),
    .out_valid_o(o_tvalid),
    .out_ready_i(o_tready)
  );

  assign o_tlast = buf_out[WIDTH];
  assign o_tdata = buf_out[WIDTH-1:0];

`ifdef SPP_REPACK_STATS_EN
  logic                  out_beat;
  logic [STAT_CNT_W-1:0] pkt_q, pkt_d;
  logic [STAT_CNT_W-1:0] split_q, split_d;

  assign out_beat = o_tvalid & o_tready;

  always_comb begin
    pkt_d   = pkt_q;
    split_d = split_q;
    if (clear) begin
      pkt_d   = '0;
      split_d = '0;
    end else begin
      if (out_beat && o_tlast) pkt_d = pkt_q + STAT_CNT_W'(1);
      if (in_beat && force_split && !i_tlast) split_d = split_q + STAT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q   <= '0;
      split_q <= '0;
    end else begin
      pkt_q   <= pkt_d;
      split_q <= split_d;
    end
  end

  assign o_pkt_count   = pkt_q;
  assign o_split_count = split_q;
`endif

endmodule
